// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU datapath.
package cpu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        JMP_ALWAYS = 2'b00,
        JMP_C      = 2'b01,
        JMP_Z      = 2'b10,
        JMP_N      = 2'b11
    } jmp_cond_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational reference adder/subtractor: recomputes the ALU sum and the
// carry/zero/negative/overflow flags from the same operands the ALU sees.
module alu_flag_calc
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] ref_result,
    output flags_t           flags
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   ref_sum;

    // Subtraction is a + ~b + 1, so carry-out of 1 means no borrow.
    always_comb begin
        b_eff      = b ^ {WIDTH{sub}};
        ref_sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        ref_result = ref_sum[WIDTH-1:0];
        flags.c    = ref_sum[WIDTH];
        flags.z    = (ref_sum[WIDTH-1:0] == '0);
        flags.n    = ref_sum[WIDTH-1];
        flags.v    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (ref_sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: bus capture with valid/ready handshake, flag register,
// conditional-jump evaluation and a sticky cross-check against a reference sum.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             eo,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid,
    input  logic             bus_ready,
    input  logic             fi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    input  logic             jmp_req,
    input  logic [1:0]       jmp_cond,
    output logic             jump_taken,
    output logic             mismatch
);

    state_t           state, state_next;
    logic             capture;
    logic             cond_met;
    logic [WIDTH-1:0] ref_result;
    flags_t           flags_calc;
    flags_t           flags_q;

    alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .a          (a),
        .b          (b),
        .sub        (sub),
        .ref_result (ref_result),
        .flags      (flags_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // While a result is held and not yet accepted, eo is ignored so bus_data stays stable.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eo) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus_ready) begin
                    if (eo) capture = 1'b1;
                    else    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cond_met = 1'b0;
        case (jmp_cond_t'(jmp_cond))
            JMP_ALWAYS: cond_met = 1'b1;
            JMP_C:      cond_met = flags_q.c;
            JMP_Z:      cond_met = flags_q.z;
            JMP_N:      cond_met = flags_q.n;
            default:    cond_met = 1'b0;
        endcase
    end

    // Jump uses flags_q before this cycle's fi update takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data   <= '0;
            flags_q    <= '0;
            jump_taken <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            if (capture) begin
                bus_data <= alu_out;
                if (alu_out != ref_result) mismatch <= 1'b1;
            end
            if (fi) flags_q <= flags_calc;
            jump_taken <= jmp_req && cond_met;
        end
    end

    assign bus_valid = (state == ST_HOLD);
    assign flag_c    = flags_q.c;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_v    = flags_q.v;

endmodule
